// File: rtl/g15_serial_pkg.sv
// Shared types for the serial accumulator: op encoding, FSM states, default word length.
package g15_serial_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_ADD  = 2'd2,
    OP_SUB  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int WORD_BITS_DEF = 29;

endpackage

// File: rtl/serial_acc_if.sv
// Control/data bundle between a sequencer (master) and the serial accumulator (slave).
interface serial_acc_if;
  import g15_serial_pkg::*;

  logic bit_en;
  logic T0;
  logic start;
  op_e  op;
  logic din;
  logic clr_ovf;
  logic dout;
  logic busy;
  logic done;
  logic ovf;

`ifdef G15_DOUBLE_PREC_EN
  logic dp;

  modport master (output bit_en, T0, start, op, din, clr_ovf, dp,
                  input  dout, busy, done, ovf);
  modport slave  (input  bit_en, T0, start, op, din, clr_ovf, dp,
                  output dout, busy, done, ovf);
`else
  modport master (output bit_en, T0, start, op, din, clr_ovf,
                  input  dout, busy, done, ovf);
  modport slave  (input  bit_en, T0, start, op, din, clr_ovf,
                  output dout, busy, done, ovf);
`endif

endinterface

// File: rtl/serial_adder_bit.sv
// One bit-slice of the serial adder/subtractor; purely combinational, no flow control.
module serial_adder_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  input  logic i_sub,
  output logic o_sum,
  output logic o_cout
);

  logic w_b;

  assign w_b    = i_b ^ i_sub;
  assign o_sum  = i_a ^ w_b ^ i_cin;
  assign o_cout = (i_a & w_b) | (i_a & i_cin) | (w_b & i_cin);

endmodule

// File: rtl/serial_acc.sv
// Bit-serial accumulator (NOP/LOAD/ADD/SUB), one bit per bit_en, done one clock after the last bit;
// no backpressure, start ignored while busy. G15_DOUBLE_PREC_EN adds the dp double-word mode.
module serial_acc
  import g15_serial_pkg::*;
#(
  parameter int WORD_BITS = WORD_BITS_DEF
) (
  input  logic        CLOCK,
  input  logic        rst_n,
  serial_acc_if.slave bus
);

`ifdef G15_DOUBLE_PREC_EN
  localparam int ACC_W = 2 * WORD_BITS;
`else
  localparam int ACC_W = WORD_BITS;
`endif
  localparam int CNT_W = $clog2(ACC_W);

  state_e           r_state;
  state_e           w_state_nxt;
  op_e              r_op;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last_idx;
  logic             r_carry;
  logic             r_done;
  logic             r_ovf;
  logic             w_step;
  logic             w_latch;
  logic             w_finish;
  logic             w_last;
  logic             w_arith;
  logic             w_sub;
  logic             w_cin;
  logic             w_sum;
  logic             w_cout;
  logic             w_res;
  logic             w_ovf_set;

`ifdef G15_DOUBLE_PREC_EN
  logic             r_dp;
  assign w_last_idx = r_dp ? CNT_W'(ACC_W - 1) : CNT_W'(WORD_BITS - 1);
`else
  assign w_last_idx = CNT_W'(WORD_BITS - 1);
`endif

  // T0 only matters while ARMED; once running every bit_en is a bit-time.
  assign w_step  = bus.bit_en &&
                   ((r_state == ST_RUN) || ((r_state == ST_ARMED) && bus.T0));
  assign w_last  = (r_cnt == w_last_idx);
  assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
  assign w_sub   = (r_op == OP_SUB);
  assign w_cin   = (r_state == ST_ARMED) ? w_sub : r_carry;

  serial_adder_bit u_add (
    .i_a    (r_acc[0]),
    .i_b    (bus.din),
    .i_cin  (w_cin),
    .i_sub  (w_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    w_res = r_acc[0];
    case (r_op)
      OP_LOAD:        w_res = bus.din;
      OP_ADD, OP_SUB: w_res = w_sum;
      default:        w_res = r_acc[0];
    endcase
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign w_ovf_set = w_finish && w_arith && (w_cin ^ w_cout);

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_ARMED;
          w_latch     = 1'b1;
        end
      end
      ST_ARMED: begin
        if (w_step) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_step && w_last) begin
          w_state_nxt = ST_IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= OP_NOP;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef G15_DOUBLE_PREC_EN
      r_dp    <= 1'b0;
`endif
    end else begin
      r_done <= w_finish;
      if (w_latch) begin
        r_op <= bus.op;
`ifdef G15_DOUBLE_PREC_EN
        r_dp <= bus.dp;
`endif
      end
      if (w_step) begin
`ifdef G15_DOUBLE_PREC_EN
        if (r_dp) r_acc <= {w_res, r_acc[ACC_W-1:1]};
        else      r_acc[WORD_BITS-1:0] <= {w_res, r_acc[WORD_BITS-1:1]};
`else
        r_acc <= {w_res, r_acc[ACC_W-1:1]};
`endif
        if (w_arith) r_carry <= w_cout;
        r_cnt <= w_finish ? '0 : r_cnt + 1'b1;
      end
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (bus.clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign bus.dout = r_acc[0];
  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = r_done;
  assign bus.ovf  = r_ovf;

endmodule

// File: doc/serial_acc.md
SERIAL_ACC -- requirements
Module: serial_acc

Interface
REQ-001 SHALL have parameter WORD_BITS, default 29, meaning serial word length in bit-times (legal range 8..64).
REQ-002 SHALL have ports: CLOCK  input  1  system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port bit_en  input  1  one-clock strobe marking one serial bit-time.
REQ-005 SHALL have port T0  input  1  qualifies bit_en as bit 0 (LSB) of a word-time.
REQ-006 SHALL have port start  input  1  request to begin an operation.
REQ-007 SHALL have port op  input  2  operation: 0 NOP (recirculate), 1 LOAD, 2 ADD, 3 SUB.
REQ-008 SHALL have port din  input  1  serial operand bit, LSB first, sampled on bit_en.
REQ-009 SHALL have port clr_ovf  input  1  clears sticky overflow.
REQ-010 SHALL have port dout  output  1  current accumulator LSB (acc[0]), registered.
REQ-011 SHALL have ports busy, done, ovf  output  1 each: operation in progress; one-clock completion pulse; sticky two's-complement overflow.

Function
REQ-012 SHALL implement FSM IDLE -> ARMED -> RUN -> IDLE.
REQ-013 SHALL, in IDLE, on start=1 latch op and enter ARMED; busy=1 from the following clock.
REQ-014 SHALL, in ARMED, enter RUN on the first clock where bit_en=1 and T0=1, processing bit 0 on that same clock.
REQ-015 SHALL, in RUN, on each bit_en shift acc right by one, inserting result bit at MSB: NOP acc[0]; LOAD din; ADD acc[0]+din+carry; SUB acc[0]+~din+carry.
REQ-016 SHALL initialise carry to 0 for ADD and 1 for SUB at bit 0; carry updated only on bit_en.
REQ-017 SHALL count bit-times; after the bit-time with count WORD_BITS-1, return to IDLE, pulse done for exactly one clock, drop busy.
REQ-018 SHALL set ovf at the final bit when carry-into-MSB XOR carry-out-of-MSB is 1 (ADD/SUB only); LOAD/NOP never set ovf.
REQ-019 SHALL hold ovf until clr_ovf=1; if set and clr_ovf coincide, set wins.
REQ-020 SHALL ignore start while busy=1; ignore T0 outside ARMED; ignore din/T0 on clocks without bit_en.
REQ-021 SHALL hold all state on clocks with bit_en=0 except FSM transition IDLE->ARMED.

Reset
REQ-022 SHALL on rst_n=0, asynchronously and mid-operation included, force IDLE, acc=0, carry=0, count=0, dout=0, busy=0, done=0, ovf=0.
REQ-023 SHALL resume only on start after rst_n deasserts; no pending operation survives reset.

Configuration
REQ-024 SHALL compile double precision in only when G15_DOUBLE_PREC_EN is defined.
REQ-025 With G15_DOUBLE_PREC_EN: extra input dp (1 bit, latched with op); dp=1 makes acc 2*WORD_BITS wide, RUN lasts 2*WORD_BITS bit-times, carry propagates across word boundary with no T0 re-sync, ovf evaluated only at final bit of second word; dp=0 behaves as single precision on the low word, high word untouched.
REQ-026 Without G15_DOUBLE_PREC_EN: no dp port, acc WORD_BITS wide, single-precision behaviour only.

Structure
REQ-027 SHALL take op encoding enum, FSM state enum and default WORD_BITS constant from shared package g15_serial_pkg.
REQ-028 SHALL instantiate one sub-module serial_adder_bit (combinational sum/carry-out from a, b, carry-in, with SUB inversion) per accumulator; carry FF stays in serial_acc.

Verification
REQ-029 WORD_BITS=29: LOAD 5, then ADD 3 -> acc=8, ovf=0, done one clock after 29th bit_en.
REQ-030 LOAD 0x0FFFFFFF, ADD 1 -> acc=0x10000000, ovf=1; clr_ovf -> ovf=0; clr_ovf with new overflow same clock -> ovf=1.
REQ-031 LOAD 8, SUB 3 -> acc=5, ovf=0; LOAD 0, SUB 1 -> acc=0x1FFFFFFF, ovf=0.
REQ-032 start pulsed at bit 10 of RUN -> ignored, single done, result unchanged; start with no T0 for 100 bit_en -> stays ARMED, busy=1.
REQ-033 rst_n low at bit 15 of ADD -> all outputs 0 immediately, acc=0, next start works normally.
REQ-034 G15_DOUBLE_PREC_EN, dp=1: LOAD 0x1FFFFFFF, ADD 1 -> acc=0x20000000, ovf=0, done after 58 bit-times.
